// File: rtl/button_export_driver.sv
// -----------------------------------------------------------------------------
// button_export_driver
//
// Fabric-side driver for the Qsys button PIO input (button_external_export).
// The raw active-low KEY pin is synchronised, debounced by a four-state FSM,
// and presented as a clean active-high level on button_export. Press and
// release edges are also reported as one-cycle pulses and captured in a
// 1-deep event register with a valid/ready handshake for fabric consumers.
//
// Optional feature macro: BUTTON_LONG_PRESS_EN
//   When defined, a hold counter runs while the button is accepted as
//   pressed and emits one long-press event (code 11) per press after
//   LONG_CYCLES cycles. When undefined, that logic is absent entirely.
//
// Ports
//   clk_clk        in   1  system clock (same domain as the bridge clk_clk)
//   reset_reset    in   1  synchronous, active-high reset
//   key_n          in   1  raw pushbutton pin, asynchronous, 0 = pressed
//   button_export  out  1  debounced level, 1 = pressed
//   press_pulse    out  1  one-cycle pulse when button_export rises
//   release_pulse  out  1  one-cycle pulse when button_export falls
//   evt_valid      out  1  event register holds an unconsumed event
//   evt_code       out  2  01 press, 10 release, 11 long press, 00 none
//   evt_ready      in   1  consumer takes the event when evt_valid & evt_ready
//   evt_overflow   out  1  sticky: an event was dropped
//   ovf_clr        in   1  clears evt_overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module button_export_driver #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       key_n,
    output logic       button_export,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_overflow,
    input  logic       ovf_clr
);

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_DN_WAIT = 2'd1,
        ST_DOWN    = 2'd2,
        ST_UP_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_PRESS   = 2'b01;
    localparam logic [1:0] CODE_RELEASE = 2'b10;
    localparam logic [1:0] CODE_LONG    = 2'b11;

    // ------------------------------------------------------------------
    // Input synchroniser. Flops preset to 1 so reset looks like "released".
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = key_n;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    logic pressed;
    assign pressed = ~sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_UP: begin
                if (pressed) begin
                    state_next = ST_DN_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_DN_WAIT: begin
                if (!pressed) begin
                    state_next = ST_UP;       // bounce rejected
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = ST_DOWN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (!pressed) begin
                    state_next = ST_UP_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_UP_WAIT: begin
                if (pressed) begin
                    state_next = ST_DOWN;     // bounce rejected
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = ST_UP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_UP;
                cnt_next   = '0;
            end
        endcase
    end

    // The level and the pulses are decoded from the next state so that they
    // are true flop outputs and change on the same edge as the state.
    logic btn_next, press_next, release_next;
    assign btn_next     = (state_next == ST_DOWN) || (state_next == ST_UP_WAIT);
    assign press_next   = (state_reg == ST_DN_WAIT) && (state_next == ST_DOWN);
    assign release_next = (state_reg == ST_UP_WAIT) && (state_next == ST_UP);

    logic button_export_reg, press_pulse_reg, release_pulse_reg;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg         <= ST_UP;
            cnt_reg           <= '0;
            button_export_reg <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            button_export_reg <= btn_next;
            press_pulse_reg   <= press_next;
            release_pulse_reg <= release_next;
        end
    end

    // ------------------------------------------------------------------
    // Long-press detection
    // ------------------------------------------------------------------
    logic long_evt;

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             in_hold;

    assign in_hold = (state_reg == ST_DOWN) || (state_reg == ST_UP_WAIT);

    // Counts only while the current state is a held state, so the count
    // equals the number of cycles since button_export rose. It parks one
    // past the trigger value, which makes the trigger fire exactly once.
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (!btn_next) begin
            hold_cnt_next = '0;
        end else if (in_hold && (hold_cnt_reg != LONG_SAT)) begin
            hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            hold_cnt_reg <= '0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign long_evt = in_hold && (hold_cnt_reg == LONG_LAST);
`else
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_CYCLES != 0);
    assign long_evt        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // 1-deep event register with valid/ready handshake
    // ------------------------------------------------------------------
    // Press, release and long events can never coincide: a press pulse
    // implies the hold count is 0, and a release pulse implies state UP.
    logic       new_evt, drop;
    logic [1:0] new_code;
    logic       evt_valid_reg, evt_valid_next;
    logic [1:0] evt_code_reg, evt_code_next;
    logic       evt_overflow_reg, evt_overflow_next;

    assign new_evt  = press_pulse_reg | release_pulse_reg | long_evt;
    assign new_code = press_pulse_reg   ? CODE_PRESS   :
                      release_pulse_reg ? CODE_RELEASE : CODE_LONG;
    assign drop     = new_evt && evt_valid_reg && !evt_ready;

    always_comb begin
        evt_valid_next = evt_valid_reg;
        evt_code_next  = evt_code_reg;
        if (new_evt) begin
            // A same-cycle pop frees the slot, so the new event is taken.
            if (!evt_valid_reg || evt_ready) begin
                evt_valid_next = 1'b1;
                evt_code_next  = new_code;
            end
        end else if (evt_valid_reg && evt_ready) begin
            evt_valid_next = 1'b0;
            evt_code_next  = CODE_NONE;
        end
    end

    always_comb begin
        evt_overflow_next = evt_overflow_reg;
        if (drop) begin
            evt_overflow_next = 1'b1;
        end else if (ovf_clr) begin
            evt_overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            evt_valid_reg    <= 1'b0;
            evt_code_reg     <= CODE_NONE;
            evt_overflow_reg <= 1'b0;
        end else begin
            evt_valid_reg    <= evt_valid_next;
            evt_code_reg     <= evt_code_next;
            evt_overflow_reg <= evt_overflow_next;
        end
    end

    assign button_export = button_export_reg;
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;
    assign evt_valid     = evt_valid_reg;
    assign evt_code      = evt_code_reg;
    assign evt_overflow  = evt_overflow_reg;

endmodule

// File: tb/tb_button_export_driver.sv
// -----------------------------------------------------------------------------
// tb_button_export_driver
//
// Self-checking bench for button_export_driver with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, LONG_CYCLES=40. Inputs change on the falling clock edge
// and outputs are sampled there too. Output vectors are packed as
// {button_export, press_pulse, release_pulse, evt_valid, evt_code[1:0],
//  evt_overflow}.
// -----------------------------------------------------------------------------
module tb_button_export_driver;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int LONG_CYCLES     = 40;
    localparam int CNT_W           = 8;

    logic       clk_clk     = 1'b0;
    logic       reset_reset = 1'b1;
    logic       key_n       = 1'b1;
    logic       evt_ready   = 1'b0;
    logic       ovf_clr     = 1'b0;
    logic       button_export;
    logic       press_pulse;
    logic       release_pulse;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_overflow;

    button_export_driver #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .CNT_W           (CNT_W)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .key_n         (key_n),
        .button_export (button_export),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .evt_valid     (evt_valid),
        .evt_code      (evt_code),
        .evt_ready     (evt_ready),
        .evt_overflow  (evt_overflow),
        .ovf_clr       (ovf_clr)
    );

    always #5 clk_clk = ~clk_clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       key_n;
        logic       rdy;
        logic       clr;
        int         n;
        logic [6:0] exp;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic k, input logic r, input logic c, input int n,
                       input logic [6:0] e, input string nm);
        vec_t v;
        v.key_n = k;
        v.rdy   = r;
        v.clr   = c;
        v.n     = n;
        v.exp   = e;
        v.nm    = nm;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
        end
    endtask

    function automatic logic [6:0] outs();
        return {button_export, press_pulse, release_pulse, evt_valid, evt_code, evt_overflow};
    endfunction

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (btn,press,rel,valid,code,ovf)", nm, act, exp);
        end else begin
            $display("ok   %s: %b", nm, act);
        end
    endtask

    int long_cnt;
    int long_exp;

    initial begin
        // Main scenario table: clean press, overflow, clear, simultaneous
        // pop + new event, and press/release with ready held high.
        add(1'b0, 1'b0, 1'b0,  9, 7'b0000000, "press_c9_quiet");
        add(1'b0, 1'b0, 1'b0,  1, 7'b1100000, "press_c10_rise");
        add(1'b0, 1'b0, 1'b0,  1, 7'b1001010, "press_c11_evt01");
        add(1'b0, 1'b0, 1'b0,  5, 7'b1001010, "press_hold_evt_kept");
        add(1'b1, 1'b0, 1'b0,  9, 7'b1001010, "rel_c9_still_down");
        add(1'b1, 1'b0, 1'b0,  1, 7'b0011010, "rel_c10_pulse");
        add(1'b1, 1'b0, 1'b0,  1, 7'b0001011, "ovf_drop_keep01");
        add(1'b1, 1'b0, 1'b1,  1, 7'b0001010, "ovf_clr");
        add(1'b1, 1'b1, 1'b0,  1, 7'b0000000, "pop_press_evt");
        add(1'b0, 1'b0, 1'b0, 10, 7'b1100000, "press2_rise");
        add(1'b0, 1'b0, 1'b0,  1, 7'b1001010, "press2_evt01");
        add(1'b1, 1'b0, 1'b0,  9, 7'b1001010, "rel2_c9");
        add(1'b1, 1'b0, 1'b0,  1, 7'b0011010, "rel2_pulse");
        add(1'b1, 1'b1, 1'b0,  1, 7'b0001100, "simul_pop_load10");
        add(1'b1, 1'b1, 1'b0,  1, 7'b0000000, "simul_then_pop");
        add(1'b0, 1'b1, 1'b0, 10, 7'b1100000, "rdy_press_rise");
        add(1'b0, 1'b1, 1'b0,  1, 7'b1001010, "rdy_press_evt");
        add(1'b0, 1'b1, 1'b0,  1, 7'b1000000, "rdy_press_popped");
        add(1'b1, 1'b1, 1'b0, 10, 7'b0010000, "rdy_rel_pulse");
        add(1'b1, 1'b1, 1'b0,  1, 7'b0001100, "rdy_rel_evt10");
        add(1'b1, 1'b1, 1'b0,  1, 7'b0000000, "rdy_rel_popped");

        // Reset state
        @(negedge clk_clk);
        step(3);
        chk("reset_state", outs(), 7'b0000000);
        reset_reset = 1'b0;
        step(3);
        chk("idle_after_reset", outs(), 7'b0000000);

        foreach (vecs[i]) begin
            key_n     = vecs[i].key_n;
            evt_ready = vecs[i].rdy;
            ovf_clr   = vecs[i].clr;
            step(vecs[i].n);
            chk(vecs[i].nm, outs(), vecs[i].exp);
        end
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;

        // Bounce: low 5, high 3, then low and held.
        key_n = 1'b0;
        step(5);
        key_n = 1'b1;
        step(3);
        key_n = 1'b0;                       // final falling edge, cycle 0
        step(4);
        chk("bounce_rejected", outs(), 7'b0000000);
        step(5);
        chk("bounce_c9_quiet", outs(), 7'b0000000);
        step(1);
        chk("bounce_c10_rise", outs(), 7'b1100000);
        step(1);
        chk("bounce_evt01", outs(), 7'b1001010);
        key_n = 1'b1;
        step(12);
        chk("bounce_released", outs(), 7'b0000000);

        // Reset 20 cycles into a hold, then re-detection of the held key.
        key_n = 1'b0;
        step(10);
        chk("hold_rise", outs(), 7'b1100000);
        step(20);
        chk("hold_c20", outs(), 7'b1000000);
        reset_reset = 1'b1;
        step(1);
        chk("reset_mid_hold", outs(), 7'b0000000);
        reset_reset = 1'b0;
        step(9);
        chk("redetect_c9_quiet", outs(), 7'b0000000);
        step(1);
        chk("redetect_c10_rise", outs(), 7'b1100000);

        // Keep holding 60 cycles past the rise and count long events.
        long_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            step(1);
            if (evt_valid && (evt_code == 2'b11)) long_cnt++;
`ifdef BUTTON_LONG_PRESS_EN
            if (i == 40) chk("long_evt_c40", outs(), 7'b1001110);
            if (i == 41) chk("long_evt_popped", outs(), 7'b1000000);
`endif
        end
`ifdef BUTTON_LONG_PRESS_EN
        long_exp = 1;
`else
        long_exp = 0;
`endif
        chk("long_evt_count", 7'(long_cnt), 7'(long_exp));
        chk("hold_c60_level", outs(), 7'b1000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
